booth_divider: RTL and testbench

- Sequential signed integer divider; the inverse operation of the team's sequential Booth multiplier.
- Shares its operand width and two's-complement conventions, and its results can be cross-checked against the multiplier.
- Restoring shift/subtract on operand magnitudes, one quotient bit per clock, with a start/ready/done handshake.
- Sits beside the multiplier in the arithmetic datapath, driven by the same control logic.

---
 rtl/arith_pkg.sv | 22 ++
 rtl/div_counter.sv | 28 ++
 rtl/booth_divider.sv | 177 +++++++++++++++++
 tb/tb_booth_divider.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions for the sequential multiplier and divider.
package arith_pkg;

  // Default operand width shared by the multiplier and the divider
  localparam int unsigned WORD_LENGTH_DEF = 16;

  // Widest operand the negate helper supports
  localparam int unsigned NEG_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's-complement negate when neg is set; callers truncate to their width
  function automatic logic [NEG_MAX_W-1:0] cond_neg(input logic [NEG_MAX_W-1:0] v,
                                                    input logic                 neg);
    return neg ? (~v + NEG_MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module div_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero_c
);

  logic [WIDTH-1:0] r_count;

  // Load has priority over decrement; hold at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: restoring shift/subtract on magnitudes, one
// quotient bit per clock, sign fix-up in a final cycle.
module booth_divider
  import arith_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = WORD_LENGTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] Dividend,
  input  logic [WORD_LENGTH-1:0] Divisor,
  output logic [WORD_LENGTH-1:0] Quotient,
  output logic [WORD_LENGTH-1:0] Remainder,
  output logic                   ready,
  output logic                   done,
  output logic                   div_by_zero
);

  localparam int unsigned CW = $clog2(WORD_LENGTH);

  state_t r_state;
  state_t w_state_nxt;

  // Control decode
  logic w_accept;
  logic w_cnt_load;
  logic w_cnt_en;
  logic w_fix;
  logic w_ready_nxt;
  logic w_done_nxt;
  logic w_cnt_zero;

  // Operand / working registers
  logic [WORD_LENGTH-1:0] r_rem;
  logic [WORD_LENGTH-1:0] r_dvd;
  logic [WORD_LENGTH-1:0] r_dsr;
  logic [WORD_LENGTH-1:0] r_dvd_raw;
  logic                   r_sign_a;
  logic                   r_sign_b;

  // Output registers
  logic [WORD_LENGTH-1:0] r_quot;
  logic [WORD_LENGTH-1:0] r_rmd;
  logic                   r_ready;
  logic                   r_done;
  logic                   r_dbz;

  // Datapath combinational signals
  logic [WORD_LENGTH-1:0] w_dvd_mag;
  logic [WORD_LENGTH-1:0] w_dsr_mag;
  logic [WORD_LENGTH:0]   w_shift;
  logic [WORD_LENGTH:0]   w_trial;
  logic                   w_qbit;
  logic [WORD_LENGTH-1:0] w_rem_nxt;
  logic                   w_dsr_zero;
  logic [WORD_LENGTH-1:0] w_quot_fix;
  logic [WORD_LENGTH-1:0] w_rmd_fix;

  // Iteration counter: loaded with N-1 on accept, counts down through CALC
  div_counter #(
    .WIDTH (CW)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (CW'(WORD_LENGTH - 1)),
    .i_en       (w_cnt_en),
    .o_zero_c   (w_cnt_zero)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (w_cnt_zero) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_accept    = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_en    = 1'b0;
    w_fix       = 1'b0;
    w_done_nxt  = 1'b0;
    w_ready_nxt = (w_state_nxt == IDLE);
    case (r_state)
      IDLE: begin
        w_accept   = start;
        w_cnt_load = start;
      end
      CALC: w_cnt_en = 1'b1;
      FIX: begin
        w_fix      = 1'b1;
        w_done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand magnitudes, one restoring step, and the sign fix-up
  always_comb begin
    w_dvd_mag  = WORD_LENGTH'(cond_neg(NEG_MAX_W'(Dividend), Dividend[WORD_LENGTH-1]));
    w_dsr_mag  = WORD_LENGTH'(cond_neg(NEG_MAX_W'(Divisor), Divisor[WORD_LENGTH-1]));
    w_shift    = {r_rem, r_dvd[WORD_LENGTH-1]};
    w_trial    = w_shift - {1'b0, r_dsr};
    w_qbit     = ~w_trial[WORD_LENGTH];
    w_rem_nxt  = w_qbit ? w_trial[WORD_LENGTH-1:0] : w_shift[WORD_LENGTH-1:0];
    w_dsr_zero = (r_dsr == '0);
    w_quot_fix = WORD_LENGTH'(cond_neg(NEG_MAX_W'(r_dvd), r_sign_a ^ r_sign_b));
    w_rmd_fix  = WORD_LENGTH'(cond_neg(NEG_MAX_W'(r_rem), r_sign_a));
  end

  // Working registers: capture on accept, shift/subtract during CALC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dsr     <= '0;
      r_dvd_raw <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
    end else if (w_accept) begin
      r_rem     <= '0;
      r_dvd     <= w_dvd_mag;
      r_dsr     <= w_dsr_mag;
      r_dvd_raw <= Dividend;
      r_sign_a  <= Dividend[WORD_LENGTH-1];
      r_sign_b  <= Divisor[WORD_LENGTH-1];
    end else if (r_state == CALC) begin
      r_rem <= w_rem_nxt;
      r_dvd <= {r_dvd[WORD_LENGTH-2:0], w_qbit};
    end
  end

  // Result registers; a zero divisor forces -1 and passes the dividend through
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_quot  <= '0;
      r_rmd   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_dbz <= 1'b0;
      end
      if (w_fix) begin
        r_quot <= w_dsr_zero ? '1 : w_quot_fix;
        r_rmd  <= w_dsr_zero ? r_dvd_raw : w_rmd_fix;
        r_dbz  <= w_dsr_zero;
      end
    end
  end

  assign Quotient    = r_quot;
  assign Remainder   = r_rmd;
  assign ready       = r_ready;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider: driver pushes expected results from a
// plain-arithmetic reference, monitor pops and compares on each done pulse.
module tb_booth_divider;

  localparam int unsigned N = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         ready;
  logic         done;
  logic         div_by_zero;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Values the outputs must hold between done pulses
  logic [N-1:0] hold_q = '0;
  logic [N-1:0] hold_r = '0;
  logic         hold_z = 1'b0;

  booth_divider #(.WORD_LENGTH(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .ready       (ready),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: C-style truncating division, zero divisor yields -1 / dividend
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int c);
    exp_t e;
    int   ai;
    int   bi;
    ai = $signed(a);
    bi = $signed(b);
    if (bi == 0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = N'(ai / bi);
      e.r = N'(ai % bi);
      e.z = 1'b0;
    end
    e.cyc = c;
    return e;
  endfunction

  // Monitor: compare on done, otherwise outputs must hold
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", 32'(Quotient), 32'(e.q));
          chk("remainder", 32'(Remainder), 32'(e.r));
          chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
          chk("done_latency_cycle", 32'(cyc), 32'(e.cyc));
          chk("ready_with_done", 32'(ready), 32'(1));
          hold_q = e.q;
          hold_r = e.r;
          hold_z = e.z;
        end
      end else begin
        chk("quotient_hold", 32'(Quotient), 32'(hold_q));
        chk("remainder_hold", 32'(Remainder), 32'(hold_r));
        chk("dbz_hold", 32'(div_by_zero), 32'(hold_z));
      end
    end
  end

  // Issue one operation as soon as ready is seen; returns after the accepting edge
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      chk("ready_timeout", 32'(ready), 32'(1));
    end else begin
      sb.push_back(model(a, b, cyc + N + 2));
      start    = 1'b1;
      Dividend = a;
      Divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      hold_z   = 1'b0;
      Dividend = N'($urandom);
      Divisor  = N'($urandom);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("pending_results", 32'(sb.size()), 32'(0));
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    hold_q = '0;
    hold_r = '0;
    hold_z = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_quotient", 32'(Quotient), 32'(0));
    chk("rst_remainder", 32'(Remainder), 32'(0));
    chk("rst_ready", 32'(ready), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_dbz", 32'(div_by_zero), 32'(0));
  endtask

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    reset    = 1'b1;
    start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("init_quotient", 32'(Quotient), 32'(0));
    chk("init_remainder", 32'(Remainder), 32'(0));
    chk("init_ready", 32'(ready), 32'(1));
    chk("init_done", 32'(done), 32'(0));
    chk("init_dbz", 32'(div_by_zero), 32'(0));

    // Directed cases, issued back to back
    do_op(16'd100, 16'd7);
    do_op(N'(-32760), 16'd2);
    do_op(N'(-7), 16'd2);
    do_op(16'd7, N'(-2));
    do_op(16'd5, 16'd0);
    do_op(16'd20, 16'd4);
    do_op(16'h8000, N'(-1));
    do_op(16'h8000, 16'd1);
    do_op(N'(-9), 16'd0);
    wait_idle();

    // Start while busy must be ignored
    do_op(16'd100, 16'd7);
    repeat (4) @(negedge clk);
    start    = 1'b1;
    Dividend = 16'd9;
    Divisor  = 16'd3;
    @(negedge clk);
    start    = 1'b0;
    wait_idle();

    // Reset during an operation discards it
    do_op(16'd5, 16'd0);
    wait_idle();
    do_op(16'd1234, 16'd11);
    repeat (6) @(posedge clk);
    apply_reset();
    repeat (25) @(negedge clk);

    // Randomized operations with biased divisors and random gaps
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin
          b = N'($urandom_range(1, 9));
          if ($urandom_range(0, 1) == 1) b = N'(-$signed(b));
        end
        2: a = 16'h8000;
        3: b = N'(-1);
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(a, b);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
